// File: rtl/mem_bus_responder.sv
// Single-port word memory answering a one-outstanding load/store request bus with fixed added latency.
// Optional build macro MISALIGN_CHECK_EN turns misaligned halfword/word accesses into error responses.
module mem_bus_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   // state | meaning
   // IDLE  | ready for a new request
   // WAIT  | request latched, counting down the added latency
   // RESP  | response presented until the core takes it

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    wait_cnt, wait_cnt_nxt;
   logic          accept;
   logic          enter_resp;

   logic          lat_we;
   logic [AW+1:0] lat_addr;
   logic [31:0]   lat_wdata;
   logic [2:0]    lat_funct3;

   logic          op_we;
   logic [AW+1:0] op_addr;
   logic [31:0]   op_wdata;
   logic [2:0]    op_funct3;
   logic [AW-1:0] op_idx;
   logic [1:0]    op_lane;
   logic          op_illegal;
   logic          op_misalign;
   logic          op_err;

   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic          mem_we;
   logic [31:0]   rd_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_data;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:AW+2];

   assign req_ready = (state == IDLE) && !reset;
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      enter_resp   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt    = WAIT;
                  wait_cnt_nxt = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we     <= req_we;
         lat_addr   <= req_addr[AW+1:0];
         lat_wdata  <= req_wdata;
         lat_funct3 <= req_funct3;
      end
   end

   // With no added latency the access completes on the accepting edge, so use the live request.
   assign op_we     = (WAIT_CYCLES == 0) ? req_we            : lat_we;
   assign op_addr   = (WAIT_CYCLES == 0) ? req_addr[AW+1:0]  : lat_addr;
   assign op_wdata  = (WAIT_CYCLES == 0) ? req_wdata         : lat_wdata;
   assign op_funct3 = (WAIT_CYCLES == 0) ? req_funct3        : lat_funct3;

   assign op_idx  = op_addr[AW+1:2];
   assign op_lane = op_addr[1:0];

   always_comb begin
      op_illegal = 1'b1;
      case (op_funct3)
         3'b000, 3'b001, 3'b010: op_illegal = 1'b0;
         3'b100, 3'b101:         op_illegal = op_we;
         default:                op_illegal = 1'b1;
      endcase
   end

`ifdef MISALIGN_CHECK_EN
   assign op_misalign = ((op_funct3[1:0] == 2'b01) && op_lane[0]) ||
                        ((op_funct3[1:0] == 2'b10) && (op_lane != 2'b00));
`else
   assign op_misalign = 1'b0;
`endif

   assign op_err = op_illegal || op_misalign;

   always_comb begin
      wr_be   = 4'b0000;
      wr_data = op_wdata;
      case (op_funct3[1:0])
         2'b00: begin
            wr_be   = 4'b0001 << op_lane;
            wr_data = {4{op_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = op_lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{op_wdata[15:0]}};
         end
         2'b10:   wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
   end

   // Reset during the entering edge drops the store, so a discarded transaction never lands.
   assign mem_we = enter_resp && !reset && op_we && !op_err;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[op_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_word  = mem[op_idx];
   assign half_sel = op_lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      byte_sel = rd_word[7:0];
      case (op_lane)
         2'd0: byte_sel = rd_word[7:0];
         2'd1: byte_sel = rd_word[15:8];
         2'd2: byte_sel = rd_word[23:16];
         2'd3: byte_sel = rd_word[31:24];
         default: byte_sel = rd_word[7:0];
      endcase
   end

   always_comb begin
      ld_data = 32'd0;
      case (op_funct3)
         3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
         3'b010:  ld_data = rd_word;
         3'b100:  ld_data = {24'd0, byte_sel};
         3'b101:  ld_data = {16'd0, half_sel};
         default: ld_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (op_err || op_we) ? 32'd0 : ld_data;
         err_q   <= op_err;
      end else if ((state == RESP) && rsp_ready) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end
   end

endmodule
